// File: rtl/sar_sequencer_if.sv
// Control/result bundle between the SAR sequencer and its wrapper/analog macro.
// The master side drives control and the comparator decision; the slave side is the sequencer.
interface sar_sequencer_if #(
  parameter int N_BITS = 8
);
  logic              en;
  logic              start;
  logic              cont;
  logic              cmp;
  logic              sample;
  logic [N_BITS-1:0] dac;
  logic [N_BITS-1:0] dout;
  logic              done;
  logic              busy;

  modport master (
    output en, start, cont, cmp,
    input  sample, dac, dout, done, busy
  );

  modport slave (
    input  en, start, cont, cmp,
    output sample, dac, dout, done, busy
  );
endinterface

// File: rtl/sar_sequencer.sv
// SAR ADC sequencer: sample window, MSB-first bit trials on the CDAC, one-cycle done strobe.
// state     | meaning
// S_IDLE    | waiting for en & start; sample/dac low
// S_SAMPLE  | sample switch closed for T_SAMPLE cycles
// S_CONVERT | bit trials, each held T_SETTLE cycles, cmp read on the last edge
// S_DONE    | one cycle: dout/done published, cont decides SAMPLE or IDLE
module sar_sequencer #(
  parameter int N_BITS   = 8,
  parameter int T_SAMPLE = 4,
  parameter int T_SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  sar_sequencer_if.slave  bus
);

  localparam int T_MAX = (T_SAMPLE > T_SETTLE) ? T_SAMPLE : T_SETTLE;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int IW    = $clog2(N_BITS);

  localparam logic [TW-1:0]     SAMPLE_LOAD = TW'(T_SAMPLE - 1);
  localparam logic [TW-1:0]     SETTLE_LOAD = TW'(T_SETTLE - 1);
  localparam logic [IW-1:0]     MSB_IDX     = IW'(N_BITS - 1);
  localparam logic [N_BITS-1:0] MSB_CODE    = {1'b1, {(N_BITS-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONVERT, S_DONE} state_t;

  state_t            state;
  logic [TW-1:0]     timer;
  logic [IW-1:0]     idx;
  logic              sample_q;
  logic              done_q;
  logic              busy_q;
  logic [N_BITS-1:0] dac_q;
  logic [N_BITS-1:0] dout_q;
  logic [N_BITS-1:0] kept;
  logic [N_BITS-1:0] next_trial;

  // The trial register doubles as the partial result: bits above idx are decided,
  // bit idx is the bit under trial, bits below are still zero.
  always_comb begin
    kept      = dac_q;
    kept[idx] = bus.cmp;
    next_trial = kept;
    if (idx != '0) next_trial[idx - IW'(1)] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      idx      <= '0;
      sample_q <= 1'b0;
      dac_q    <= '0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (!bus.en) begin
      // dout deliberately untouched: an aborted conversion never publishes.
      state    <= S_IDLE;
      timer    <= '0;
      idx      <= '0;
      sample_q <= 1'b0;
      dac_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state    <= S_SAMPLE;
            sample_q <= 1'b1;
            busy_q   <= 1'b1;
            timer    <= SAMPLE_LOAD;
            dac_q    <= '0;
          end
        end
        S_SAMPLE: begin
          if (timer == '0) begin
            state    <= S_CONVERT;
            sample_q <= 1'b0;
            dac_q    <= MSB_CODE;
            idx      <= MSB_IDX;
            timer    <= SETTLE_LOAD;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_CONVERT: begin
          if (timer == '0) begin
            if (idx == '0) begin
              state  <= S_DONE;
              dac_q  <= kept;
              dout_q <= kept;
              done_q <= 1'b1;
            end else begin
              dac_q <= next_trial;
              idx   <= idx - IW'(1);
              timer <= SETTLE_LOAD;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_DONE: begin
          if (bus.cont) begin
            state    <= S_SAMPLE;
            sample_q <= 1'b1;
            timer    <= SAMPLE_LOAD;
            dac_q    <= '0;
          end else begin
            state  <= S_IDLE;
            dac_q  <= '0;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          sample_q <= 1'b0;
          dac_q    <= '0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sample = sample_q;
  assign bus.dac    = dac_q;
  assign bus.dout   = dout_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_sar_sequencer.sv
// Self-checking bench for sar_sequencer: default timing instance and a T_SAMPLE=2/T_SETTLE=3 instance.
// Expected trial codes and timing come from closed-form arithmetic on the input code.
module tb_sar_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic en, start, cont, cmp;

  always #5 clk = ~clk;

  sar_sequencer_if #(.N_BITS(8)) bus0 ();
  sar_sequencer_if #(.N_BITS(8)) bus1 ();

  assign bus0.en = en;  assign bus0.start = start;  assign bus0.cont = cont;  assign bus0.cmp = cmp;
  assign bus1.en = en;  assign bus1.start = start;  assign bus1.cont = cont;  assign bus1.cmp = cmp;

  sar_sequencer #(.N_BITS(8), .T_SAMPLE(4), .T_SETTLE(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  sar_sequencer #(.N_BITS(8), .T_SAMPLE(2), .T_SETTLE(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  bit         sel;
  logic       o_sample, o_done, o_busy;
  logic [7:0] o_dac, o_dout;

  always_comb begin
    o_sample = sel ? bus1.sample : bus0.sample;
    o_done   = sel ? bus1.done   : bus0.done;
    o_busy   = sel ? bus1.busy   : bus0.busy;
    o_dac    = sel ? bus1.dac    : bus0.dac;
    o_dout   = sel ? bus1.dout   : bus0.dout;
  end

  int         tests = 0;
  int         fails = 0;
  logic [7:0] model_dout;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Trial code for bit i of an ideal conversion of `code`: decided upper bits plus bit i.
  function automatic logic [7:0] trial(input logic [7:0] code, input int i);
    int v;
    v = (int'(code) & (256 - (2 << i))) | (1 << i);
    return 8'(v);
  endfunction

  task automatic go_idle();
    en = 1'b0; start = 1'b0; cont = 1'b0;
    step();
    en = 1'b1;
  endtask

  // kind: 0 ideal comparator, 1 cmp tied 0, 2 cmp tied 1, 3 ideal on sampling edges / random elsewhere
  task automatic run_conv(input logic [7:0] code, input int kind, input bit noisy_start);
    int ts, tt, ed, b, nxt, ns, nd;
    bit exp_s, exp_d, exp_b, sampling;
    logic [7:0] exp_dac;
    ts = sel ? 2 : 4;
    tt = sel ? 3 : 1;
    ed = ts + 8 * tt;
    ns = 0; nd = 0;
    en = 1'b1; cont = 1'b0; start = 1'b1;
    for (int k = 0; k <= ed + 1; k++) begin
      step();
      start = (noisy_start && k <= ed) ? 1'($urandom_range(1, 0)) : 1'b0;
      exp_s = (k < ts);
      exp_d = (k == ed);
      exp_b = (k <= ed);
      if (k < ts) exp_dac = 8'h00;
      else if (k < ed) begin
        b = (k - ts) / tt;
        exp_dac = trial(code, 7 - b);
      end else if (k == ed) exp_dac = code;
      else exp_dac = 8'h00;
      if (k == ed) model_dout = code;
      tests++; if (o_sample !== exp_s) begin fails++; $display("FAIL conv_sample k=%0d: got %b expected %b", k, o_sample, exp_s); end
      tests++; if (o_dac !== exp_dac) begin fails++; $display("FAIL conv_dac k=%0d: got %h expected %h", k, o_dac, exp_dac); end
      tests++; if (o_done !== exp_d) begin fails++; $display("FAIL conv_done k=%0d: got %b expected %b", k, o_done, exp_d); end
      tests++; if (o_busy !== exp_b) begin fails++; $display("FAIL conv_busy k=%0d: got %b expected %b", k, o_busy, exp_b); end
      tests++; if (o_dout !== model_dout) begin fails++; $display("FAIL conv_dout k=%0d: got %h expected %h", k, o_dout, model_dout); end
      if (o_sample === 1'b1) ns++;
      if (o_done === 1'b1) nd++;
      nxt = k + 1;
      sampling = (nxt >= ts + tt) && (nxt <= ed) && (((nxt - ts) % tt) == 0);
      case (kind)
        1: cmp = 1'b0;
        2: cmp = 1'b1;
        default: cmp = (kind == 3 && !sampling) ? 1'($urandom_range(1, 0)) : (code >= exp_dac);
      endcase
    end
    tests++; if (ns != ts) begin fails++; $display("FAIL sample_len: got %0d expected %0d", ns, ts); end
    tests++; if (nd != 1) begin fails++; $display("FAIL done_count: got %0d expected 1", nd); end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst = 1'b1; en = 1'b0; start = 1'b0; cont = 1'b0; cmp = 1'b0;
    step(); step();
    model_dout = 8'h00;
    tests++; if ({o_sample, o_dac, o_dout, o_done, o_busy} !== 19'd0) begin fails++; $display("FAIL reset_init: got %h expected 0", {o_sample, o_dac, o_dout, o_done, o_busy}); end
    rst = 1'b0; en = 1'b1; start = 1'b1;
    step();
    start = 1'b0; cmp = 1'b1;
    repeat (6) step();
    tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL reset_pre_busy: got %b expected 1", o_busy); end
    for (int j = 0; j < 5; j++) begin
      rst = (j < 2);
      step();
      tests++; if ({o_sample, o_dac, o_dout, o_done, o_busy} !== 19'd0) begin fails++; $display("FAIL reset_hold j=%0d: got %h expected 0", j, {o_sample, o_dac, o_dout, o_done, o_busy}); end
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    sel = 1'b0;
    go_idle();
    run_conv(8'hA5, 0, 1'b0);
  endtask

  task automatic test_extremes();
    sel = 1'b0;
    go_idle();
    run_conv(8'h00, 1, 1'b0);
    go_idle();
    run_conv(8'hFF, 2, 1'b0);
  endtask

  task automatic test_random();
    sel = 1'b0;
    repeat (4) begin
      go_idle();
      run_conv(8'($urandom), 3, 1'b0);
    end
  endtask

  task automatic test_start_ignore();
    sel = 1'b0;
    go_idle();
    run_conv(8'($urandom), 0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      tests++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin fails++; $display("FAIL start_ignore k=%0d: got busy=%b done=%b expected 0/0", k, o_busy, o_done); end
    end
  endtask

  task automatic test_abort();
    logic [7:0] code, exp_dac;
    sel = 1'b0;
    go_idle();
    code = 8'($urandom);
    en = 1'b1; start = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      step();
      start = 1'b0;
      exp_dac = (k < 4) ? 8'h00 : trial(code, 7 - (k - 4));
      cmp = (code >= exp_dac);
    end
    tests++; if (o_dac !== trial(code, 3)) begin fails++; $display("FAIL abort_bit3_dac: got %h expected %h", o_dac, trial(code, 3)); end
    en = 1'b0;
    step();
    tests++; if ({o_sample, o_dac, o_done, o_busy} !== 11'd0) begin fails++; $display("FAIL abort_idle: got %h expected 0", {o_sample, o_dac, o_done, o_busy}); end
    tests++; if (o_dout !== model_dout) begin fails++; $display("FAIL abort_dout: got %h expected %h", o_dout, model_dout); end
    en = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step();
      tests++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL abort_quiet k=%0d: got busy=%b done=%b expected 0/0", k, o_busy, o_done); end
    end
    tests++; if (o_dout !== model_dout) begin fails++; $display("FAIL abort_dout_after: got %h expected %h", o_dout, model_dout); end
  endtask

  task automatic test_continuous();
    logic [7:0] codes [3];
    logic [7:0] exp_dac;
    int j, p, nd;
    bit exp_s, exp_d, exp_b;
    codes[0] = 8'h01; codes[1] = 8'h7F; codes[2] = 8'hFE;
    sel = 1'b0;
    go_idle();
    nd = 0;
    en = 1'b1; cont = 1'b1; start = 1'b1;
    for (int k = 0; k <= 42; k++) begin
      step();
      start = 1'b0;
      j = (k / 13 > 2) ? 2 : k / 13;
      p = k % 13;
      if (k <= 38) begin
        exp_b = 1'b1;
        exp_s = (p < 4);
        exp_d = (p == 12);
        exp_dac = (p < 4) ? 8'h00 : (p < 12) ? trial(codes[j], 7 - (p - 4)) : codes[j];
        if (p == 12) model_dout = codes[j];
      end else begin
        exp_b = 1'b0; exp_s = 1'b0; exp_d = 1'b0; exp_dac = 8'h00;
      end
      tests++; if (o_sample !== exp_s) begin fails++; $display("FAIL cont_sample k=%0d: got %b expected %b", k, o_sample, exp_s); end
      tests++; if (o_dac !== exp_dac) begin fails++; $display("FAIL cont_dac k=%0d: got %h expected %h", k, o_dac, exp_dac); end
      tests++; if (o_done !== exp_d) begin fails++; $display("FAIL cont_done k=%0d: got %b expected %b", k, o_done, exp_d); end
      tests++; if (o_busy !== exp_b) begin fails++; $display("FAIL cont_busy k=%0d: got %b expected %b", k, o_busy, exp_b); end
      tests++; if (o_dout !== model_dout) begin fails++; $display("FAIL cont_dout k=%0d: got %h expected %h", k, o_dout, model_dout); end
      if (o_done === 1'b1) nd++;
      cmp = (codes[j] >= exp_dac);
      if (k == 30) cont = 1'b0;
    end
    tests++; if (nd != 3) begin fails++; $display("FAIL cont_done_count: got %0d expected 3", nd); end
  endtask

  task automatic test_params();
    sel = 1'b1;
    rst = 1'b1; en = 1'b0; start = 1'b0; cont = 1'b0;
    step();
    rst = 1'b0;
    model_dout = 8'h00;
    run_conv(8'hA5, 3, 1'b0);
    go_idle();
    run_conv(8'($urandom), 3, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_random();
    test_continuous();
    test_abort();
    test_start_ignore();
    test_params();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
